param_seq_detector: RTL and testbench

- Parametrised Moore serial-pattern detector; generalises the fixed 5-bit overlapping detector to any pattern of 2..16 bits.
- Overlap/non-overlap mode is selectable at run time. Adds a sample enable, a saturating match counter and a synchronous counter clear.
- Sits on a 1-bit serial stream in the day-to-day FSM library; its output feeds event counters or interrupt logic.

---
 rtl/param_seq_detector.sv | 128 ++++++++++++
 tb/tb_param_seq_detector.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/param_seq_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// param_seq_detector : parametrised Moore serial-pattern detector with run-time
//   overlap select, sample enable and a saturating match counter.
//   Optional sticky "found" flag enabled by defining SEQDET_STICKY_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module param_seq_detector #(
  parameter int                   SEQ_LEN = 5,
  parameter logic [SEQ_LEN-1:0]   PATTERN = 5'b10110,
  parameter int                   CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             ovl,
  input  logic             clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             found
);

  // Pattern bit i counted from the MSB (the first bit received).
  function automatic logic pat_bit(input int i);
    logic [SEQ_LEN-1:0] t;
    t = PATTERN >> (SEQ_LEN - 1 - i);
    return t[0];
  endfunction

  // Longest prefix of PATTERN that is a suffix of (first k pattern bits, b).
  function automatic int calc_next(input int k, input logic b);
    int   res;
    logic ok;
    logic sbit;
    res = 0;
    for (int j = 1; j <= k + 1; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        sbit = ((k + 1 - j + i) < k) ? pat_bit(k + 1 - j + i) : b;
        if (pat_bit(i) != sbit) ok = 1'b0;
      end
      if (ok) res = j;
    end
    return res;
  endfunction

  // Longest proper prefix of PATTERN that is also its suffix.
  function automatic int calc_fail();
    int   res;
    logic ok;
    res = 0;
    for (int j = 1; j < SEQ_LEN; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (pat_bit(i) != pat_bit(SEQ_LEN - j + i)) ok = 1'b0;
      end
      if (ok) res = j;
    end
    return res;
  endfunction

  localparam int             SW      = $clog2(SEQ_LEN + 1);
  localparam int             NSLOT   = 1 << SW;
  localparam logic [SW-1:0]  S_IDLE  = '0;
  localparam logic [SW-1:0]  S_MATCH = SW'(SEQ_LEN);
  localparam logic [SW-1:0]  S_FAIL  = SW'(calc_fail());
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SW-1:0] state;
  logic [SW-1:0] next_state;
  logic [SW-1:0] base;
  logic [SW-1:0] trans0 [0:NSLOT-1];
  logic [SW-1:0] trans1 [0:NSLOT-1];
  logic          hit;

  // Elaboration-time transition constants; slots past the last partial state are unused.
  for (genvar k = 0; k < NSLOT; k++) begin : g_trans
    if (k < SEQ_LEN) begin : g_live
      assign trans0[k] = SW'(calc_next(k, 1'b0));
      assign trans1[k] = SW'(calc_next(k, 1'b1));
    end else begin : g_pad
      assign trans0[k] = S_IDLE;
      assign trans1[k] = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    base = state;
    if (state == S_MATCH)     base = ovl ? S_FAIL : S_IDLE;
    else if (state > S_MATCH) base = S_IDLE;
    next_state = state;
    if (en) next_state = din ? trans1[base] : trans0[base];
  end

  always_comb begin
    dout = (state == S_MATCH);
  end

  assign hit = (next_state == S_MATCH) && ((state != S_MATCH) || en);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           match_cnt <= '0;
    else if (clr)                       match_cnt <= '0;
    else if (hit && match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
  end

`ifdef SEQDET_STICKY_EN
  logic found_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     found_q <= 1'b0;
    else if (clr) found_q <= 1'b0;
    else if (hit) found_q <= 1'b1;
  end

  assign found = found_q;
`else
  assign found = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_seq_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_param_seq_detector : directed self-checking bench for param_seq_detector.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_param_seq_detector;

  logic       clk;
  logic       rst;
  logic       en;
  logic       din;
  logic       ovl;
  logic       clr;

  logic       dout_m, found_m;
  logic [7:0] cnt_m;
  logic       dout_s, found_s;
  logic [1:0] cnt_s;
  logic       dout_g, found_g;
  logic [7:0] cnt_g;

  int nvec = 0;
  int nerr = 0;

  param_seq_detector u_main (
    .clk(clk), .rst(rst), .en(en), .din(din), .ovl(ovl), .clr(clr),
    .dout(dout_m), .match_cnt(cnt_m), .found(found_m)
  );

  param_seq_detector #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .din(din), .ovl(ovl), .clr(clr),
    .dout(dout_s), .match_cnt(cnt_s), .found(found_s)
  );

  param_seq_detector #(.SEQ_LEN(4), .PATTERN(4'b1111), .CNT_W(8)) u_gen (
    .clk(clk), .rst(rst), .en(en), .din(din), .ovl(ovl), .clr(clr),
    .dout(dout_g), .match_cnt(cnt_g), .found(found_g)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    din = b;
    en  = 1'b1;
    tick();
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    chk("async_rst_dout", {31'd0, dout_m}, 32'd0);
    chk("async_rst_cnt", {24'd0, cnt_m}, 32'd0);
    rst = 1'b1;
  endtask

  // Send n bits MSB-first and check the selected dout after each edge.
  task automatic run(input logic [31:0] bits, input logic [31:0] expd, input int n,
                     input string tag, input int which);
    logic obs;
    for (int i = 0; i < n; i++) begin
      send(bits[n-1-i]);
      obs = (which == 1) ? dout_g : dout_m;
      chk($sformatf("%s[%0d]", tag, i), {31'd0, obs}, {31'd0, expd[n-1-i]});
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    en  = 1'b1;
    din = 1'b0;
    ovl = 1'b1;
    clr = 1'b0;

    // Reset held for two edges, then idle zeros.
    repeat (2) tick();
    chk("rst_dout", {31'd0, dout_m}, 32'd0);
    chk("rst_cnt", {24'd0, cnt_m}, 32'd0);
    chk("rst_found", {31'd0, found_m}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1'b0);
      chk("idle_dout", {31'd0, dout_m}, 32'd0);
      chk("idle_cnt", {24'd0, cnt_m}, 32'd0);
      chk("idle_found", {31'd0, found_m}, 32'd0);
    end

    // Overlapping: 10110110 matches after bits 5 and 8.
    ovl = 1'b1;
    run(32'b10110110, 32'b00001001, 8, "ovl_dout", 0);
    chk("ovl_cnt", {24'd0, cnt_m}, 32'd2);

    // Clear while disabled: count clears, MATCH state holds.
    en = 1'b0; clr = 1'b1; din = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_hold_dout", {31'd0, dout_m}, 32'd1);
    chk("clr_hold_cnt", {24'd0, cnt_m}, 32'd0);

    // Non-overlapping: same stream, one match.
    ovl = 1'b0;
    pulse_reset();
    run(32'b10110110, 32'b00001000, 8, "novl_dout", 0);
    chk("novl_cnt", {24'd0, cnt_m}, 32'd1);

    // Enable gap in the middle of a pattern.
    ovl = 1'b1;
    pulse_reset();
    run(32'b101, 32'b000, 3, "gap_a", 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = ~din;
      tick();
    end
    chk("gap_hold_dout", {31'd0, dout_m}, 32'd0);
    run(32'b10, 32'b01, 2, "gap_b", 0);
    chk("gap_cnt", {24'd0, cnt_m}, 32'd1);

    // Async reset mid-pattern wipes progress.
    run(32'b101, 32'b000, 3, "mid_a", 0);
    pulse_reset();
    run(32'b10, 32'b00, 2, "mid_b", 0);
    chk("mid_cnt", {24'd0, cnt_m}, 32'd0);
    chk("mid_dout", {31'd0, dout_m}, 32'd0);

    // Five back-to-back overlapping matches: 2-bit counter saturates at 3.
    pulse_reset();
    run(32'b10110110110110110, 32'b00001001001001001, 17, "sat_dout", 0);
    chk("sat_cnt_s", {30'd0, cnt_s}, 32'd3);
    chk("sat_cnt_m", {24'd0, cnt_m}, 32'd5);

    // Clear on the edge that completes a match: clear wins, dout still rises.
    run(32'b11, 32'b00, 2, "clrm_pre", 0);
    clr = 1'b1;
    send(1'b0);
    clr = 1'b0;
    chk("clrm_cnt_s", {30'd0, cnt_s}, 32'd0);
    chk("clrm_cnt_m", {24'd0, cnt_m}, 32'd0);
    chk("clrm_dout", {31'd0, dout_s}, 32'd1);
    chk("clrm_found", {31'd0, found_s}, 32'd0);

    // Generality: 4-bit all-ones pattern.
    ovl = 1'b1;
    pulse_reset();
    run(32'b1111111, 32'b0001111, 7, "gen_ovl", 1);
    chk("gen_ovl_cnt", {24'd0, cnt_g}, 32'd4);
    ovl = 1'b0;
    pulse_reset();
    run(32'b1111111, 32'b0001000, 7, "gen_novl", 1);
    chk("gen_novl_cnt", {24'd0, cnt_g}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
